// File: rtl/systolic_feed_ctrl_if.sv
// -----------------------------------------------------------------------------
// systolic_feed_ctrl_if
// Input vector stream into the systolic feed controller.
//
// Signals:
//   in_vec_valid   producer offers a vector this cycle
//   out_vec_ready  controller can take a vector this cycle
//   in_vec_data    ROW bytes; byte r (bits [r*8 +: 8]) is meant for lane r
//
// Handshake: a beat transfers on a rising clock edge where in_vec_valid and
// out_vec_ready are both 1. Once valid is raised the producer holds valid and
// data stable until that transfer; ready never depends on valid.
//
// Modports:
//   master  producer side (drives valid/data, observes ready)
//   slave   controller side (observes valid/data, drives ready)
// -----------------------------------------------------------------------------
interface systolic_feed_ctrl_if #(
    parameter int ROW = 9
) ();
    logic               in_vec_valid;
    logic               out_vec_ready;
    logic [ROW*8-1:0]   in_vec_data;

    modport master (
        output in_vec_valid,
        output in_vec_data,
        input  out_vec_ready
    );

    modport slave (
        input  in_vec_valid,
        input  in_vec_data,
        output out_vec_ready
    );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_feed_ctrl
// Job controller for a ROW x COL systolic grid with west-side delay registers.
// Accepts N vectors over the vec stream, drives each onto the west lanes as
// {valid, byte} words for one cycle (zero bubbles otherwise), keeps the north
// partial sums at zero, then captures one south result per vector using the
// grid's last-row valid flag delayed by SOUTH_LAT. Ends with a one-cycle done
// pulse; a sticky error flag is set if results stop arriving while draining.
//
// Ports:
//   in_clk, in_rst_n   clock, asynchronous active-low reset
//   in_start           job start (sampled only in IDLE)
//   in_num_vec         vector count N, sampled with in_start
//   vec                vector stream (slave modport)
//   out_west           to grid in_west; lane r = bits [(ROW-r)*9-1 -: 9]
//   out_north          to grid in_north; always zero
//   in_last_valid      grid last-row valid flag
//   in_south           grid south output words
//   out_res_valid      one-cycle result strobe
//   out_res_data       captured result
//   out_busy           job in FEED or DRAIN
//   out_done           one-cycle job-complete pulse
//   out_err            sticky drain-timeout flag
//   out_state          current FSM state (debug)
// -----------------------------------------------------------------------------
module systolic_feed_ctrl #(
    parameter int ROW       = 9,
    parameter int COL       = 1,
    parameter int SOUTH_LAT = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_start,
    input  logic [7:0]           in_num_vec,
    systolic_feed_ctrl_if.slave  vec,
    output logic [ROW*9-1:0]     out_west,
    output logic [COL*32-1:0]    out_north,
    input  logic                 in_last_valid,
    input  logic [COL*32-1:0]    in_south,
    output logic                 out_res_valid,
    output logic [COL*32-1:0]    out_res_data,
    output logic                 out_busy,
    output logic                 out_done,
    output logic                 out_err,
    output logic [1:0]           out_state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      num_vec;
    logic [7:0]      acc_cnt;
    logic [7:0]      res_cnt;
    logic [WD_W-1:0] wd;
    logic            vtap;
    logic            xfer;
    logic            capture;

    assign out_north     = '0;
    assign out_state     = state;
    assign vec.out_vec_ready = (state == FEED);
    assign xfer          = vec.in_vec_valid && (state == FEED);
    // Valid flags seen outside a job are left over from earlier grid contents.
    assign capture       = vtap && (state == FEED || state == DRAIN);

    // Align the last-row valid flag with the south word it qualifies.
    generate
        if (SOUTH_LAT == 0) begin : g_no_delay
            assign vtap = in_last_valid;
        end else begin : g_delay
            logic [SOUTH_LAT-1:0] sr;
            always_ff @(posedge in_clk or negedge in_rst_n) begin
                if (!in_rst_n) begin
                    sr <= '0;
                end else begin
                    sr <= (sr << 1) | SOUTH_LAT'(in_last_valid);
                end
            end
            assign vtap = sr[SOUTH_LAT-1];
        end
    endgenerate

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state         <= IDLE;
            num_vec       <= '0;
            acc_cnt       <= '0;
            res_cnt       <= '0;
            wd            <= '0;
            out_west      <= '0;
            out_res_valid <= 1'b0;
            out_res_data  <= '0;
            out_busy      <= 1'b0;
            out_done      <= 1'b0;
            out_err       <= 1'b0;
        end else begin
            // West lanes carry a vector for exactly one cycle after its
            // transfer; every other cycle is an all-zero bubble.
            out_west <= '0;
            if (xfer) begin
                for (int r = 0; r < ROW; r++) begin
                    out_west[(ROW-r)*9-1 -: 9] <= {1'b1, vec.in_vec_data[r*8 +: 8]};
                end
            end

            out_res_valid <= 1'b0;
            if (capture) begin
                out_res_data  <= in_south;
                out_res_valid <= 1'b1;
                res_cnt       <= res_cnt + 8'd1;
            end

            out_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_start) begin
                        num_vec <= in_num_vec;
                        acc_cnt <= '0;
                        res_cnt <= '0;
                        wd      <= '0;
                        out_err <= 1'b0;
                        if (in_num_vec != 8'd0) begin
                            state    <= FEED;
                            out_busy <= 1'b1;
                        end else begin
                            state    <= DONE;
                            out_done <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (xfer) begin
                        acc_cnt <= acc_cnt + 8'd1;
                        if (acc_cnt + 8'd1 == num_vec) begin
                            state <= DRAIN;
                            wd    <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (capture) begin
                        wd <= '0;
                        // Last result: done pulse lines up with its strobe.
                        if (res_cnt + 8'd1 == num_vec) begin
                            state    <= DONE;
                            out_done <= 1'b1;
                            out_busy <= 1'b0;
                        end
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        out_err  <= 1'b1;
                        state    <= DONE;
                        out_done <= 1'b1;
                        out_busy <= 1'b0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
module tb_systolic_feed_ctrl;

    localparam int ROW       = 9;
    localparam int COL       = 1;
    localparam int SOUTH_LAT = 1;
    localparam int TIMEOUT   = 64;
    localparam int DPIPE     = ROW - 1 + SOUTH_LAT;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic                in_start = 1'b0;
    logic [7:0]          in_num_vec = 8'd0;
    logic [ROW*9-1:0]    out_west;
    logic [COL*32-1:0]   out_north;
    logic                in_last_valid;
    logic [COL*32-1:0]   in_south;
    logic                out_res_valid;
    logic [COL*32-1:0]   out_res_data;
    logic                out_busy;
    logic                out_done;
    logic                out_err;
    logic [1:0]          out_state;

    systolic_feed_ctrl_if #(.ROW(ROW)) vec_if ();

    systolic_feed_ctrl #(
        .ROW(ROW), .COL(COL), .SOUTH_LAT(SOUTH_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_start      (in_start),
        .in_num_vec    (in_num_vec),
        .vec           (vec_if),
        .out_west      (out_west),
        .out_north     (out_north),
        .in_last_valid (in_last_valid),
        .in_south      (in_south),
        .out_res_valid (out_res_valid),
        .out_res_data  (out_res_data),
        .out_busy      (out_busy),
        .out_done      (out_done),
        .out_err       (out_err),
        .out_state     (out_state)
    );

    // ---------------- behavioral grid ----------------
    // Lane-0 valid reaches the last row ROW-1 cycles later; the south word
    // (sum of lane bytes, unit weights) follows SOUTH_LAT cycles after that.
    logic [ROW-2:0] lv_pipe = '0;
    logic [31:0]    d_pipe [0:DPIPE-1];
    logic [31:0]    lane_sum;
    logic           force_lv = 1'b0;
    logic           grid_kill = 1'b0;

    initial for (int i = 0; i < DPIPE; i++) d_pipe[i] = 32'd0;

    always_comb begin
        lane_sum = 32'd0;
        for (int r = 0; r < ROW; r++) lane_sum = lane_sum + 32'(out_west[(ROW-r)*9-2 -: 8]);
    end

    always @(posedge clk) begin
        lv_pipe   <= {lv_pipe[ROW-3:0], out_west[ROW*9-1]};
        d_pipe[0] <= lane_sum;
        for (int i = 1; i < DPIPE; i++) d_pipe[i] <= d_pipe[i-1];
    end

    always_comb begin
        in_last_valid = grid_kill ? 1'b0 : (force_lv | lv_pipe[ROW-2]);
        in_south      = d_pipe[DPIPE-1];
    end

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    logic [ROW*8-1:0] vec_tab[$];
    bit               pat[$];
    logic [31:0]      exp_q[$];

    int               ready_cnt, ready_first, busy_cnt, busy_fall, done_cyc;
    int               west0_cnt, west0_first, west0_last;
    logic             err_c0, err_done;
    int               res_cyc[$];
    logic [31:0]      res_dat[$];
    logic [ROW*9-1:0] west_log [0:127];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a job and plays vec_tab through the stream using pat as the
    // per-cycle valid pattern (1 beyond its end), logging what comes out.
    // Cycle 0 is the first cycle after the start edge.
    task automatic drive_job(input int n, input int budget);
        int vi;
        bit vv;
        bit seen_busy;
        ready_cnt = 0; ready_first = -1; busy_cnt = 0; busy_fall = -1; done_cyc = -1;
        west0_cnt = 0; west0_first = -1; west0_last = -1; err_c0 = 1'b0; err_done = 1'b0;
        res_cyc.delete(); res_dat.delete();
        vi = 0; seen_busy = 0;
        in_start = 1'b1;
        in_num_vec = 8'(n);
        vec_if.in_vec_valid = 1'b0;
        step();
        in_start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c == 0) err_c0 = out_err;
            if (vec_if.out_vec_ready) begin
                ready_cnt++;
                if (ready_first < 0) ready_first = c;
            end
            if (out_busy) begin
                busy_cnt++;
                seen_busy = 1;
            end else if (seen_busy && busy_fall < 0) begin
                busy_fall = c;
            end
            if (c < 128) west_log[c] = out_west;
            if (out_west[ROW*9-1]) begin
                west0_cnt++;
                if (west0_first < 0) west0_first = c;
                west0_last = c;
            end
            if (out_res_valid) begin
                res_cyc.push_back(c);
                res_dat.push_back(out_res_data);
            end
            if (out_done && done_cyc < 0) begin
                done_cyc = c;
                err_done = out_err;
            end
            vv = (vi < vec_tab.size()) && ((c < pat.size()) ? pat[c] : 1'b1);
            vec_if.in_vec_valid = vv;
            vec_if.in_vec_data  = (vi < vec_tab.size()) ? vec_tab[vi] : '0;
            if (vv && vec_if.out_vec_ready) vi++;
            step();
            if (done_cyc >= 0) break;
        end
        vec_if.in_vec_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int nres;
        rst_n = 1'b0;
        vec_if.in_vec_valid = 1'b0;
        vec_if.in_vec_data = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({vec_if.out_vec_ready, out_res_valid, out_busy, out_done, out_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {vec_if.out_vec_ready, out_res_valid, out_busy, out_done, out_err});
        end
        checks++;
        if (out_west !== '0 || out_north !== '0 || out_res_data !== '0) begin
            errors++;
            $display("FAIL reset_buses: west=%h north=%h res=%h expected all 0", out_west, out_north, out_res_data);
        end
        checks++;
        if (out_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", out_state);
        end

        // Valid flags from the grid while idle must be ignored.
        force_lv = 1'b1;
        nres = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_res_valid) nres++;
        end
        force_lv = 1'b0;
        repeat (2) begin
            step();
            if (out_res_valid) nres++;
        end
        checks++;
        if (nres !== 0) begin
            errors++;
            $display("FAIL idle_last_valid: got %0d strobes expected 0", nres);
        end

        // Asynchronous reset in the middle of a clock during a job.
        in_start = 1'b1;
        in_num_vec = 8'd3;
        vec_if.in_vec_valid = 1'b1;
        vec_if.in_vec_data = 72'h090807060504030201;
        step();
        in_start = 1'b0;
        step();
        checks++;
        if (out_busy !== 1'b1 || out_west[ROW*9-1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_job: busy=%b lane0_valid=%b expected 1 1", out_busy, out_west[ROW*9-1]);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vec_if.out_vec_ready, out_busy, out_res_valid, out_done} !== 4'b0 || out_west !== '0
            || out_state !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: ready=%b busy=%b west=%h state=%0d expected all 0",
                     vec_if.out_vec_ready, out_busy, out_west, out_state);
        end
        vec_if.in_vec_valid = 1'b0;
        step();
        rst_n = 1'b1;
        nres = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (out_res_valid) nres++;
        end
        checks++;
        if (nres !== 0) begin
            errors++;
            $display("FAIL stale_after_reset: got %0d strobes expected 0", nres);
        end
    endtask

    task automatic test_streaming();
        logic [ROW*9-1:0] exp_west;
        int first_res;
        vec_tab.delete(); pat.delete(); exp_q.delete();
        vec_tab.push_back(72'h090807060504030201); exp_q.push_back(32'd45);
        vec_tab.push_back(72'h101010101010101010); exp_q.push_back(32'd144);
        vec_tab.push_back(72'hFF00FF00FF00FF00FF); exp_q.push_back(32'd1275);
        exp_west = {9'h101, 9'h102, 9'h103, 9'h104, 9'h105, 9'h106, 9'h107, 9'h108, 9'h109};
        drive_job(3, 40);

        checks++;
        if (ready_cnt !== 3 || ready_first !== 0) begin
            errors++;
            $display("FAIL stream_ready: got cnt=%0d first=%0d expected cnt=3 first=0", ready_cnt, ready_first);
        end
        checks++;
        if (west0_first !== 1 || west0_cnt !== 3 || west0_last !== 3) begin
            errors++;
            $display("FAIL stream_lane0: got first=%0d cnt=%0d last=%0d expected 1 3 3",
                     west0_first, west0_cnt, west0_last);
        end
        checks++;
        if (west_log[1] !== exp_west) begin
            errors++;
            $display("FAIL stream_west_lanes: got %h expected %h", west_log[1], exp_west);
        end
        first_res = (res_cyc.size() > 0) ? res_cyc[0] : -1;
        checks++;
        if (first_res !== 11) begin
            errors++;
            $display("FAIL stream_latency: first result cycle %0d expected 11", first_res);
        end
        checks++;
        if (res_dat.size() !== 3) begin
            errors++;
            $display("FAIL stream_count: got %0d results expected 3", res_dat.size());
        end
        for (int i = 0; i < res_dat.size() && exp_q.size() > 0; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (res_dat[i] !== e) begin
                errors++;
                $display("FAIL stream_data[%0d]: got %0d expected %0d", i, res_dat[i], e);
            end
        end
        checks++;
        if (done_cyc !== 13 || busy_fall !== 13) begin
            errors++;
            $display("FAIL stream_done: done=%0d busy_fall=%0d expected 13 13", done_cyc, busy_fall);
        end
    endtask

    task automatic test_bubbles();
        int first_res;
        vec_tab.delete(); pat.delete(); exp_q.delete();
        vec_tab.push_back({9{8'h01}}); exp_q.push_back(32'd9);
        vec_tab.push_back({9{8'h02}}); exp_q.push_back(32'd18);
        vec_tab.push_back({9{8'h03}}); exp_q.push_back(32'd27);
        vec_tab.push_back({9{8'h04}}); exp_q.push_back(32'd36);
        pat.push_back(1); pat.push_back(0); pat.push_back(1);
        pat.push_back(0); pat.push_back(1); pat.push_back(1);
        drive_job(4, 40);

        checks++;
        if (west_log[2] !== '0 || west_log[4] !== '0) begin
            errors++;
            $display("FAIL bubble_gap: got c2=%h c4=%h expected 0", west_log[2], west_log[4]);
        end
        checks++;
        if (west_log[6] !== {9{9'h104}}) begin
            errors++;
            $display("FAIL bubble_last_beat: got %h expected %h", west_log[6], {9{9'h104}});
        end
        checks++;
        if (res_dat.size() !== 4) begin
            errors++;
            $display("FAIL bubble_count: got %0d results expected 4", res_dat.size());
        end
        for (int i = 0; i < res_dat.size() && exp_q.size() > 0; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (res_dat[i] !== e) begin
                errors++;
                $display("FAIL bubble_data[%0d]: got %0d expected %0d", i, res_dat[i], e);
            end
        end
        first_res = (res_cyc.size() > 0) ? res_cyc[0] : -1;
        checks++;
        if (first_res !== 11 || done_cyc !== 16) begin
            errors++;
            $display("FAIL bubble_timing: first=%0d done=%0d expected 11 16", first_res, done_cyc);
        end
    endtask

    task automatic test_zero_vectors();
        vec_tab.delete(); pat.delete();
        drive_job(0, 10);
        checks++;
        if (done_cyc !== 0) begin
            errors++;
            $display("FAIL zero_done: got cycle %0d expected 0", done_cyc);
        end
        checks++;
        if (ready_cnt !== 0 || busy_cnt !== 0) begin
            errors++;
            $display("FAIL zero_idle: ready=%0d busy=%0d expected 0 0", ready_cnt, busy_cnt);
        end
        checks++;
        if (out_state !== 2'd0 || out_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_return: state=%0d done=%b expected 0 0", out_state, out_done);
        end
    endtask

    task automatic test_timeout();
        vec_tab.delete(); pat.delete();
        vec_tab.push_back({9{8'h01}});
        vec_tab.push_back({9{8'h02}});
        grid_kill = 1'b1;
        drive_job(2, 100);
        checks++;
        if (done_cyc !== 66 || err_done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_done: done=%0d err=%b expected 66 1", done_cyc, err_done);
        end
        checks++;
        if (res_dat.size() !== 0) begin
            errors++;
            $display("FAIL timeout_results: got %0d expected 0", res_dat.size());
        end
        repeat (3) step();
        grid_kill = 1'b0;
        checks++;
        if (out_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b expected 1", out_err);
        end
        vec_tab.delete();
        drive_job(0, 10);
        checks++;
        if (err_c0 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b expected 0", err_c0);
        end
    endtask

    task automatic test_reset_in_drain();
        int nres;
        int first_res;
        in_start = 1'b1;
        in_num_vec = 8'd5;
        vec_if.in_vec_valid = 1'b1;
        vec_if.in_vec_data = {9{8'h11}};
        step();
        in_start = 1'b0;
        nres = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_res_valid) nres++;
            if (nres == 2) break;
            step();
        end
        checks++;
        if (nres !== 2 || out_res_data !== 32'd153) begin
            errors++;
            $display("FAIL drain_pre_reset: got %0d results data=%0d expected 2 153", nres, out_res_data);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_res_data !== '0 || out_res_valid !== 1'b0 || out_busy !== 1'b0 || out_state !== 2'd0) begin
            errors++;
            $display("FAIL drain_reset: data=%0d valid=%b busy=%b state=%0d expected 0 0 0 0",
                     out_res_data, out_res_valid, out_busy, out_state);
        end
        vec_if.in_vec_valid = 1'b0;
        step();
        rst_n = 1'b1;
        nres = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_res_valid) nres++;
        end
        checks++;
        if (nres !== 0) begin
            errors++;
            $display("FAIL drain_stale: got %0d strobes expected 0", nres);
        end

        vec_tab.delete(); pat.delete();
        vec_tab.push_back({9{8'h05}});
        drive_job(1, 40);
        first_res = (res_dat.size() > 0) ? int'(res_dat[0]) : -1;
        checks++;
        if (res_dat.size() !== 1 || first_res !== 45) begin
            errors++;
            $display("FAIL drain_new_job: got %0d results first=%0d expected 1 45", res_dat.size(), first_res);
        end
        checks++;
        if (done_cyc !== 11 || err_done !== 1'b0) begin
            errors++;
            $display("FAIL drain_new_done: done=%0d err=%b expected 11 0", done_cyc, err_done);
        end
    endtask

    task automatic test_back_to_back();
        int first_res;
        vec_tab.delete(); pat.delete();
        vec_tab.push_back({9{8'h07}});
        drive_job(1, 40);
        first_res = (res_dat.size() > 0) ? int'(res_dat[0]) : -1;
        checks++;
        if (done_cyc !== 11 || first_res !== 63) begin
            errors++;
            $display("FAIL b2b_first: done=%0d data=%0d expected 11 63", done_cyc, first_res);
        end
        vec_tab.delete();
        vec_tab.push_back({9{8'h08}});
        drive_job(1, 40);
        first_res = (res_dat.size() > 0) ? int'(res_dat[0]) : -1;
        checks++;
        if (ready_first !== 0 || done_cyc !== 11 || first_res !== 72) begin
            errors++;
            $display("FAIL b2b_second: ready_first=%0d done=%0d data=%0d expected 0 11 72",
                     ready_first, done_cyc, first_res);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_streaming();
        test_bubbles();
        test_zero_vectors();
        test_timeout();
        test_reset_in_drain();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "simulation time limit");
    end

endmodule
